// File: rtl/spi_ram_burst.sv
// Command-driven RAM with separate write/read pointers and an RD_LAT-deep read pipeline.
// Rejected addresses and unarmed reads raise a one-cycle err pulse.
module spi_ram_burst #(
   parameter int MEM_WIDTH = 8,
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int RD_LAT    = 1,
   parameter int AUTO_INC  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_valid,
   input  logic [MEM_WIDTH+1:0] rx_data,
   output logic                 tx_valid,
   output logic [MEM_WIDTH-1:0] dout,
   output logic                 err
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_SIZE:0]   DEPTH_X = (ADDR_SIZE+1)'(MEM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] LAST_A  = ADDR_SIZE'(MEM_DEPTH - 1);

   typedef enum logic [1:0] {
      OP_WADDR = 2'b00,
      OP_WDATA = 2'b01,
      OP_RADDR = 2'b10,
      OP_RDATA = 2'b11
   } op_e;

   function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
      return (p == LAST_A) ? '0 : p + 1'b1;
   endfunction

   op_e                  op;
   logic [MEM_WIDTH-1:0] payload;
   logic [ADDR_SIZE-1:0] addr_in;
   logic                 addr_ok;
   logic [ADDR_SIZE-1:0] wr_ptr;
   logic [ADDR_SIZE-1:0] rd_ptr;
   logic                 rd_armed;
   logic                 wr_fire;
   logic                 rd_fire;
   logic [RD_LAT-1:0]    vld_p;
   logic [MEM_WIDTH-1:0] rd_word;
   logic [MEM_WIDTH-1:0] last_in;
   logic                 last_ld;

   logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

   assign op      = op_e'(rx_data[MEM_WIDTH+1:MEM_WIDTH]);
   assign payload = rx_data[MEM_WIDTH-1:0];
   assign addr_in = payload[ADDR_SIZE-1:0];
   assign addr_ok = {1'b0, addr_in} < DEPTH_X;
   assign wr_fire = rx_valid && (op == OP_WDATA);
   assign rd_fire = rx_valid && (op == OP_RDATA) && rd_armed;
   assign rd_word = mem[IDX_W'(rd_ptr)];

   // Storage: never reset, so contents survive rst_n
   always_ff @(posedge clk) begin
      if (wr_fire) mem[IDX_W'(wr_ptr)] <= payload;
   end

   // Command decode, pointers and pipeline valid bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_armed <= 1'b0;
         err      <= 1'b0;
         vld_p    <= '0;
      end else begin
         err <= rx_valid && ((((op == OP_WADDR) || (op == OP_RADDR)) && !addr_ok) ||
                             ((op == OP_RDATA) && !rd_armed));
         vld_p[0] <= rd_fire;
         for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
         if (rx_valid) begin
            case (op)
               OP_WADDR: if (addr_ok) wr_ptr <= addr_in;
               OP_WDATA: if (AUTO_INC != 0) wr_ptr <= next_ptr(wr_ptr);
               OP_RADDR: if (addr_ok) begin
                  rd_ptr   <= addr_in;
                  rd_armed <= 1'b1;
               end
               OP_RDATA: if (rd_armed && (AUTO_INC != 0)) rd_ptr <= next_ptr(rd_ptr);
               default: ;
            endcase
         end
      end
   end

   // Read stages p0..p(RD_LAT-2); the final stage is the dout register
   generate
      if (RD_LAT == 1) begin : g_direct
         assign last_in = rd_word;
         assign last_ld = rd_fire;
      end else begin : g_stages
         logic [MEM_WIDTH-1:0] data_p [RD_LAT-1];
         always_ff @(posedge clk) begin
            if (rd_fire) data_p[0] <= rd_word;
            for (int k = 1; k < RD_LAT - 1; k++) begin
               if (vld_p[k-1]) data_p[k] <= data_p[k-1];
            end
         end
         assign last_in = data_p[RD_LAT-2];
         assign last_ld = vld_p[RD_LAT-2];
      end
   endgenerate

   // Output stage: dout only moves when a read completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout <= '0;
      else if (last_ld) dout <= last_in;
   end

   assign tx_valid = vld_p[RD_LAT-1];

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 Parameter MEM_WIDTH, default 8: data word width in bits.
REQ-002 Parameter MEM_DEPTH, default 256: number of words; any value 2..2**ADDR_SIZE, need not be a power of two.
REQ-003 Parameter ADDR_SIZE, default 8: address width in bits; ADDR_SIZE <= MEM_WIDTH.
REQ-004 Parameter RD_LAT, default 1: read latency in cycles, legal range 1..4.
REQ-005 Parameter AUTO_INC, default 1: 1 = post-increment the address pointers after each data access; 0 = pointers hold.
REQ-006 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-007 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 Port rx_valid  input  1  rx_data carries a command this cycle.
REQ-009 Port rx_data  input  MEM_WIDTH+2  command: bits [MEM_WIDTH+1:MEM_WIDTH] opcode, bits [MEM_WIDTH-1:0] payload.
REQ-010 Port tx_valid  output  1  one-cycle pulse; dout holds valid read data.
REQ-011 Port dout  output  MEM_WIDTH  read data.
REQ-012 Port err  output  1  one-cycle pulse flagging a rejected command.

Function
REQ-013 The block SHALL decode opcodes 2'b00 write-address, 2'b01 write-data, 2'b10 read-address and 2'b11 read-data, and SHALL act on a command only in a cycle with rx_valid=1.
REQ-014 Write-address SHALL load wr_ptr with payload[ADDR_SIZE-1:0]; if that value >= MEM_DEPTH, the block SHALL leave wr_ptr unchanged and pulse err on the next cycle.
REQ-015 Read-address SHALL load rd_ptr under the same rule and SHALL set flag rd_armed=1 when the load is accepted.
REQ-016 Write-data SHALL store payload into mem[wr_ptr] at that clock edge.
REQ-017 With AUTO_INC=1, write-data SHALL then set wr_ptr to wr_ptr+1, wrapping MEM_DEPTH-1 -> 0.
REQ-018 Read-data with rd_armed=1 SHALL sample mem[rd_ptr] at the command edge, with memory contents as they stand before any later command.
REQ-019 The sampled word SHALL pass through an RD_LAT-stage pipeline; tx_valid=1 and dout=word exactly RD_LAT cycles after the command edge.
REQ-020 With AUTO_INC=1, read-data SHALL then set rd_ptr to rd_ptr+1, wrapping MEM_DEPTH-1 -> 0.
REQ-021 Read-data with rd_armed=0 SHALL leave memory and pointers unchanged, produce no tx_valid, and pulse err on the next cycle.
REQ-022 Back-to-back read-data commands SHALL be accepted every cycle, yielding consecutive tx_valid pulses with no bubbles.
REQ-023 The pipeline SHALL hold up to RD_LAT reads in flight; a write to a location already sampled SHALL NOT alter that read's result.
REQ-024 dout SHALL hold its last value while tx_valid=0.
REQ-025 err SHALL be registered, one cycle per offending command, and SHALL NOT interact with tx_valid.
REQ-026 With AUTO_INC=0, both pointers SHALL change only on accepted address commands.
REQ-027 All rx_data bits above ADDR_SIZE-1 SHALL be ignored for address commands.

Reset
REQ-028 While rst_n=0, the block SHALL hold wr_ptr=0, rd_ptr=0, rd_armed=0, tx_valid=0, dout=0, err=0, and all pipeline valid bits=0.
REQ-029 Reset asserted mid-read SHALL discard all in-flight reads; no tx_valid SHALL appear after reset release for commands issued before reset.
REQ-030 Memory contents SHALL NOT be reset and SHALL retain their values across reset.
REQ-031 The first command SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 Defaults: write-addr 0x10, write-data 0xA5, read-addr 0x10, read-data -> tx_valid 1 cycle later, dout=0xA5.
REQ-033 Burst: write-addr 0xFE, write-data 0x11, 0x22, 0x33, then read-addr 0xFE and 3 back-to-back read-data -> dout 0x11, 0x22, 0x33 on consecutive cycles (wrap 0xFF -> 0x00).
REQ-034 MEM_DEPTH=200: write-addr 0xC8 -> err pulse, wr_ptr unchanged; read-data after reset with no read-addr -> err pulse, no tx_valid.
REQ-035 RD_LAT=3: read-data at cycle N -> tx_valid at N+3 only; write-data to the same address at N+1 -> dout shows the old value.
REQ-036 Reset mid-flight: RD_LAT=4, read-data, then rst_n low for 1 cycle at +2 -> no tx_valid ever; memory word still readable after re-arming.
REQ-037 AUTO_INC=0: two write-data 0x01 then 0x02 at addr 0x05 -> read of 0x05 returns 0x02 twice.
